// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo family: default geometry, depth helper and
// the per-cycle accepted-request record.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic int depth(input int asize);
    return 2 ** asize;
  endfunction

  typedef struct packed {
    logic wacc;
    logic racc;
  } fifo_acc_t;

endpackage

// File: rtl/fifo_ram.sv
// 1-write/1-read register array; synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int DEPTH = depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_sync_thr.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_thr
  import fifo_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int ASIZE      = ASIZE_DEF,
  parameter int AFULL_THR  = 14,
  parameter int AEMPTY_THR = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             winc_i,
  input  logic [DSIZE-1:0] wdata_i,
  output logic             wfull_o,
  output logic             walmost_full_o,
  input  logic             rinc_i,
  output logic [DSIZE-1:0] rdata_o,
  output logic             rempty_o,
  output logic             ralmost_empty_o,
  output logic [ASIZE:0]   count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int DEPTH = depth(ASIZE);
  localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_THR);
  localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_THR);

  if (AFULL_THR > DEPTH || AEMPTY_THR >= DEPTH) begin : g_bad_thr
    $error("fifo_sync_thr: threshold out of range (AFULL_THR=%0d AEMPTY_THR=%0d DEPTH=%0d)",
           AFULL_THR, AEMPTY_THR, DEPTH);
  end

  logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic           overflow_q, underflow_q;
  logic           full, empty;
  logic [DSIZE-1:0] ram_rdata;
  fifo_acc_t      acc;

  // Extra pointer MSB distinguishes full (MSBs differ, addresses equal) from empty.
  assign full  = (wptr_q == {~rptr_q[ASIZE], rptr_q[ASIZE-1:0]});
  assign empty = (wptr_q == rptr_q);

  always_comb begin
    acc.wacc = winc_i & ~full;
    acc.racc = rinc_i & ~empty;
    wptr_d   = wptr_q + (ASIZE+1)'(acc.wacc);
    rptr_d   = rptr_q + (ASIZE+1)'(acc.racc);
    count_d  = count_q;
    case ({acc.wacc, acc.racc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_q | (winc_i & full);
      underflow_q <= underflow_q | (rinc_i & empty);
    end
  end

  fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (acc.wacc & ~rst_i),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign rdata_o = ram_rdata;
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)         rdata_q <= '0;
    else if (acc.racc) rdata_q <= ram_rdata;
  end

  assign rdata_o = rdata_q;
`endif

  assign wfull_o         = full;
  assign rempty_o        = empty;
  assign walmost_full_o  = (count_q >= AFULL_CNT);
  assign ralmost_empty_o = (count_q <= AEMPTY_CNT);
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;
  assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Directed bench for fifo_sync_thr: vector table plus hand-written corner sequences.
module tb_fifo_sync_thr;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = '0;
  logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  fifo_sync_thr #(
    .DSIZE(8), .ASIZE(4), .AFULL_THR(14), .AEMPTY_THR(2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .winc_i          (winc),
    .wdata_i         (wdata),
    .wfull_o         (wfull),
    .walmost_full_o  (walmost_full),
    .rinc_i          (rinc),
    .rdata_o         (rdata),
    .rempty_o        (rempty),
    .ralmost_empty_o (ralmost_empty),
    .count_o         (count),
    .overflow_o      (overflow),
    .underflow_o     (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;
    logic [4:0] expCount;
    logic [5:0] expFlags;
    logic       chkRdata;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  // Flags ordered {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}.
  function automatic logic [5:0] flg(input int c, input bit ovf, input bit unf);
    return {c == 16, c >= 14, c == 0, c <= 2, ovf, unf};
  endfunction

  function automatic vec_t mk(input string n, input bit r, input bit w, input bit rd,
                              input logic [7:0] d, input int c, input logic [5:0] f,
                              input bit cr, input logic [7:0] rv);
    vec_t v;
    v.name = n; v.rst = r; v.winc = w; v.rinc = rd; v.wdata = d;
    v.expCount = 5'(c); v.expFlags = f; v.chkRdata = cr; v.expRdata = rv;
    return v;
  endfunction

  function automatic logic [5:0] actFlags();
    return {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow};
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [7:0] d);
    rst = r; winc = w; rinc = rd; wdata = d;
    @(posedge clk);
    #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
  endtask

  // In FWFT mode the word is visible before the pop; otherwise after it.
  task automatic popCheck(input string name, input int idx, input logic [7:0] exp);
    if (FWFT) begin
      checkOutput(name, idx, 32'(rdata), 32'(exp));
      applyStimulus(0, 0, 1, 8'h00);
    end else begin
      applyStimulus(0, 0, 1, 8'h00);
      checkOutput(name, idx, 32'(rdata), 32'(exp));
    end
  endtask

  initial begin
    // Reset, underflow on empty, fill to full, overflow, drain, read-while-empty hold.
    vecs.push_back(mk("reset", 1, 0, 0, 8'h00, 0, flg(0, 0, 0), 1, 8'h00));
    vecs.push_back(mk("rd_empty", 0, 0, 1, 8'h00, 0, flg(0, 0, 1), 1, 8'h00));
    vecs.push_back(mk("reset2", 1, 0, 0, 8'h00, 0, flg(0, 0, 0), 1, 8'h00));
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk("fill", 0, 1, 0, 8'(i), i, flg(i, 0, 0), 0, 8'h00));
    vecs.push_back(mk("ovf_write", 0, 1, 0, 8'hAA, 16, flg(16, 1, 0), 0, 8'h00));
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk("drain", 0, 0, 1, 8'h00, 16 - k, flg(16 - k, 1, 0), 1, 8'(k)));
    vecs.push_back(mk("rd_hold", 0, 0, 1, 8'h00, 0, flg(0, 1, 1), 1, 8'h10));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].winc, vecs[i].rinc, vecs[i].wdata);
      checkOutput({vecs[i].name, "_count"}, i, 32'(count), 32'(vecs[i].expCount));
      checkOutput({vecs[i].name, "_flags"}, i, 32'(actFlags()), 32'(vecs[i].expFlags));
      if (vecs[i].chkRdata && !FWFT)
        checkOutput({vecs[i].name, "_rdata"}, i, 32'(rdata), 32'(vecs[i].expRdata));
    end

    // Steady-state streaming at half occupancy; addresses wrap several times.
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'(i));
    checkOutput("stream_prefill", 0, 32'(count), 32'd8);
    for (int j = 0; j < 40; j++) begin
      applyStimulus(0, 1, 1, 8'(8 + j));
      checkOutput("stream_count", j, 32'(count), 32'd8);
      checkOutput("stream_rdata", j, 32'(rdata), FWFT ? 32'(j + 1) : 32'(j));
    end

    // Empty with both requests: only the write lands, underflow sets.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h42);
    checkOutput("empty_both_flags", 0, 32'(actFlags()), 32'(flg(1, 0, 1)));
    checkOutput("empty_both_count", 0, 32'(count), 32'd1);
    popCheck("empty_both_word", 0, 8'h42);

    // Full with both requests: only the read lands, overflow sets, 0xEE never stored.
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(8'h60 + i));
    if (FWFT) checkOutput("full_both_head", 0, 32'(rdata), 32'h60);
    applyStimulus(0, 1, 1, 8'hEE);
    checkOutput("full_both_flags", 0, 32'(actFlags()), 32'(flg(15, 1, 0)));
    if (!FWFT) checkOutput("full_both_rdata", 0, 32'(rdata), 32'h60);
    for (int i = 1; i < 16; i++) popCheck("full_both_drain", i, 8'(8'h60 + i));
    checkOutput("full_both_end", 0, 32'(actFlags()), 32'(flg(0, 1, 0)));

    // Reset mid-operation with a concurrent write: everything discarded.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'(8'h31 + i));
    checkOutput("midrst_pre", 0, 32'(count), 32'd5);
    applyStimulus(1, 1, 0, 8'h77);
    checkOutput("midrst_count", 0, 32'(count), 32'd0);
    checkOutput("midrst_flags", 0, 32'(actFlags()), 32'(flg(0, 0, 0)));
    applyStimulus(0, 1, 0, 8'h99);
    popCheck("midrst_word", 0, 8'h99);
    checkOutput("midrst_after", 0, 32'(actFlags()), 32'(flg(0, 0, 0)));

`ifdef FIFO_FWFT_EN
    // Fall-through: the word appears without a read request.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h5C);
    checkOutput("fwft_empty", 0, 32'(rempty), 32'd0);
    checkOutput("fwft_rdata", 0, 32'(rdata), 32'h5C);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("fwft_pop", 0, 32'(rempty), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
